// File: rtl/enigma_pkg.sv
// Shared Enigma constants: rotor I..V wirings, their inverses, turnover notches
// and the output-stage state encoding.
package enigma_pkg;

    localparam int ALPHA_DEFAULT = 26;
    localparam int W_DEFAULT     = 5;
    localparam int TBL_N         = 26;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ostate_e;

    // Letter A..Z encoded as 0..25; row r is rotor r+1 (I..V).
    localparam logic [4:0] WIRE [5][26] = '{
        '{5'd4,  5'd10, 5'd12, 5'd5,  5'd11, 5'd6,  5'd3,  5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
          5'd22, 5'd24, 5'd7,  5'd23, 5'd20, 5'd18, 5'd15, 5'd0,  5'd8,  5'd1,  5'd17, 5'd2,  5'd9},
        '{5'd0,  5'd9,  5'd3,  5'd10, 5'd18, 5'd8,  5'd17, 5'd20, 5'd23, 5'd1,  5'd11, 5'd7,  5'd22,
          5'd19, 5'd12, 5'd2,  5'd16, 5'd6,  5'd25, 5'd13, 5'd15, 5'd24, 5'd5,  5'd21, 5'd14, 5'd4},
        '{5'd1,  5'd3,  5'd5,  5'd7,  5'd9,  5'd11, 5'd2,  5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
          5'd13, 5'd24, 5'd4,  5'd8,  5'd22, 5'd6,  5'd0,  5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14},
        '{5'd4,  5'd18, 5'd14, 5'd21, 5'd15, 5'd25, 5'd9,  5'd0,  5'd24, 5'd16, 5'd20, 5'd8,  5'd17,
          5'd7,  5'd23, 5'd11, 5'd13, 5'd5,  5'd19, 5'd6,  5'd10, 5'd3,  5'd2,  5'd12, 5'd22, 5'd1},
        '{5'd21, 5'd25, 5'd1,  5'd17, 5'd6,  5'd8,  5'd19, 5'd24, 5'd20, 5'd15, 5'd18, 5'd3,  5'd13,
          5'd7,  5'd11, 5'd23, 5'd0,  5'd22, 5'd12, 5'd9,  5'd16, 5'd14, 5'd5,  5'd4,  5'd2,  5'd10}
    };

    localparam logic [4:0] INV [5][26] = '{
        '{5'd20, 5'd22, 5'd24, 5'd6,  5'd0,  5'd3,  5'd5,  5'd15, 5'd21, 5'd25, 5'd1,  5'd4,  5'd2,
          5'd10, 5'd12, 5'd19, 5'd7,  5'd23, 5'd18, 5'd11, 5'd17, 5'd8,  5'd13, 5'd16, 5'd14, 5'd9},
        '{5'd0,  5'd9,  5'd15, 5'd2,  5'd25, 5'd22, 5'd17, 5'd11, 5'd5,  5'd1,  5'd3,  5'd10, 5'd14,
          5'd19, 5'd24, 5'd20, 5'd16, 5'd6,  5'd4,  5'd13, 5'd7,  5'd23, 5'd12, 5'd8,  5'd21, 5'd18},
        '{5'd19, 5'd0,  5'd6,  5'd1,  5'd15, 5'd2,  5'd18, 5'd3,  5'd16, 5'd4,  5'd20, 5'd5,  5'd21,
          5'd13, 5'd25, 5'd7,  5'd24, 5'd8,  5'd23, 5'd9,  5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12},
        '{5'd7,  5'd25, 5'd22, 5'd21, 5'd0,  5'd17, 5'd19, 5'd13, 5'd11, 5'd6,  5'd20, 5'd15, 5'd23,
          5'd16, 5'd2,  5'd4,  5'd9,  5'd12, 5'd1,  5'd18, 5'd10, 5'd3,  5'd24, 5'd14, 5'd8,  5'd5},
        '{5'd16, 5'd2,  5'd24, 5'd11, 5'd23, 5'd22, 5'd4,  5'd13, 5'd5,  5'd19, 5'd25, 5'd14, 5'd18,
          5'd12, 5'd21, 5'd9,  5'd20, 5'd3,  5'd10, 5'd6,  5'd8,  5'd0,  5'd17, 5'd15, 5'd7,  5'd1}
    };

    // Turnover letters Q, E, V, J, Z.
    localparam logic [4:0] NOTCH [5] = '{5'd16, 5'd4, 5'd21, 5'd9, 5'd25};

endpackage

// File: rtl/enigma_mod_add.sv
// Modular add/subtract of two residues in [0, ALPHA) using one conditional
// correction by ALPHA; no divider.
module enigma_mod_add #(
    parameter int W     = 5,
    parameter int ALPHA = 26
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_y
);

    localparam logic [W:0] ALPHA_X = (W+1)'(ALPHA);

    logic [W:0] w_sum;
    logic [W:0] w_diff;

    // One extra bit holds the carry/borrow so a single correction suffices.
    always_comb begin
        w_sum  = {1'b0, i_a} + {1'b0, i_b};
        w_diff = {1'b0, i_a} - {1'b0, i_b};
        if (i_sub) begin
            if (i_a >= i_b) begin
                o_y = w_diff[W-1:0];
            end else begin
                o_y = W'(w_diff + ALPHA_X);
            end
        end else begin
            if (w_sum >= ALPHA_X) begin
                o_y = W'(w_sum - ALPHA_X);
            end else begin
                o_y = w_sum[W-1:0];
            end
        end
    end

endmodule

// File: rtl/enigma_rotor_stage.sv
// One Enigma rotor: offset-adjusted wiring lookup in either direction, a
// one-deep registered valid/ready output stage, and position/notch stepping.
module enigma_rotor_stage
    import enigma_pkg::*;
#(
    parameter int ALPHA    = ALPHA_DEFAULT,
    parameter int W        = W_DEFAULT,
    parameter int ROTOR_ID = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_load,
    input  logic [W-1:0] cfg_pos,
    input  logic [W-1:0] cfg_ring,
    input  logic         step_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_dir,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_err,
    output logic [W-1:0] position,
    output logic         notch_out
);

    ostate_e      r_state;
    ostate_e      w_state_nxt;
    logic [W-1:0] r_pos;
    logic [W-1:0] r_ring;
    logic [W-1:0] r_out_data;
    logic         r_out_err;
    logic         r_notch;

    logic         w_accept;
    logic         w_err;
    logic [W-1:0] w_t0;
    logic [W-1:0] w_idx;
    logic [W-1:0] w_tbl;
    logic [W-1:0] w_t2;
    logic [W-1:0] w_res;
    logic [4:0]   w_tidx;
    logic [4:0]   w_traw;
    logic [W-1:0] w_pos_inc;
    logic [W-1:0] w_cfg_pos;
    logic [W-1:0] w_cfg_ring;

    assign out_valid = (r_state == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_err     = (int'(in_data) >= ALPHA);

    assign w_pos_inc  = (int'(r_pos) == ALPHA - 1) ? {W{1'b0}} : r_pos + W'(1'b1);
    assign w_cfg_pos  = (int'(cfg_pos)  >= ALPHA) ? cfg_pos  - W'(ALPHA) : cfg_pos;
    assign w_cfg_ring = (int'(cfg_ring) >= ALPHA) ? cfg_ring - W'(ALPHA) : cfg_ring;

    enigma_mod_add #(.W(W), .ALPHA(ALPHA)) u_in_pos (
        .i_a(in_data), .i_b(r_pos),  .i_sub(1'b0), .o_y(w_t0)
    );
    enigma_mod_add #(.W(W), .ALPHA(ALPHA)) u_in_ring (
        .i_a(w_t0),    .i_b(r_ring), .i_sub(1'b1), .o_y(w_idx)
    );
    enigma_mod_add #(.W(W), .ALPHA(ALPHA)) u_out_pos (
        .i_a(w_tbl),   .i_b(r_pos),  .i_sub(1'b1), .o_y(w_t2)
    );
    enigma_mod_add #(.W(W), .ALPHA(ALPHA)) u_out_ring (
        .i_a(w_t2),    .i_b(r_ring), .i_sub(1'b0), .o_y(w_res)
    );

    // Wiring lookup; entries outside a shrunken alphabet fall back to identity.
    always_comb begin
        w_tidx = 5'(w_idx);
        w_traw = in_dir ? INV[ROTOR_ID][w_tidx] : WIRE[ROTOR_ID][w_tidx];
        if (int'(w_idx) < TBL_N && int'(w_traw) < ALPHA) begin
            w_tbl = W'(w_traw);
        end else begin
            w_tbl = w_idx;
        end
    end

    // Output-stage state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output-stage next state: a drain with no refill empties the slot.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_FULL;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_ready && !w_accept) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Result capture; held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data <= {W{1'b0}};
            r_out_err  <= 1'b0;
        end else if (w_accept) begin
            r_out_data <= w_err ? in_data : w_res;
            r_out_err  <= w_err;
        end
    end

    // Position, ring and carry; a load takes priority over a step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos   <= {W{1'b0}};
            r_ring  <= {W{1'b0}};
            r_notch <= 1'b0;
        end else begin
            r_notch <= step_in && !cfg_load && (r_pos == W'(NOTCH[ROTOR_ID]));
            if (cfg_load) begin
                r_pos  <= w_cfg_pos;
                r_ring <= w_cfg_ring;
            end else if (step_in) begin
                r_pos <= w_pos_inc;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_err   = r_out_err;
    assign position  = r_pos;
    assign notch_out = r_notch;

endmodule

// File: tb/tb_enigma_rotor_stage.sv
// Directed bench for enigma_rotor_stage with rotor I: vector table for the
// mapping plus hand sequences for stepping, backpressure and reset.
module tb_enigma_rotor_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_load;
    logic [4:0] cfg_pos;
    logic [4:0] cfg_ring;
    logic       step_in;
    logic       in_valid;
    logic       in_ready;
    logic       in_dir;
    logic [4:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_data;
    logic       out_err;
    logic [4:0] position;
    logic       notch_out;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       dir;
        logic [4:0] pos;
        logic [4:0] ring;
        logic [4:0] data;
        logic [4:0] exp_pos;
        logic [4:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs [12];

    enigma_rotor_stage #(.ALPHA(26), .W(5), .ROTOR_ID(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_load(cfg_load), .cfg_pos(cfg_pos), .cfg_ring(cfg_ring),
        .step_in(step_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_dir(in_dir), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
        .position(position), .notch_out(notch_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] p, input logic [4:0] r);
        cfg_load = 1'b1;
        cfg_pos  = p;
        cfg_ring = r;
        tick();
        cfg_load = 1'b0;
    endtask

    initial begin
        // dir, pos, ring, data, exp_pos, exp_data, exp_err
        vecs[0]  = '{1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  5'd4,  1'b0};
        vecs[1]  = '{1'b0, 5'd1,  5'd0,  5'd0,  5'd1,  5'd9,  1'b0};
        vecs[2]  = '{1'b1, 5'd0,  5'd0,  5'd4,  5'd0,  5'd0,  1'b0};
        vecs[3]  = '{1'b0, 5'd0,  5'd0,  5'd27, 5'd0,  5'd27, 1'b1};
        vecs[4]  = '{1'b0, 5'd0,  5'd0,  5'd25, 5'd0,  5'd9,  1'b0};
        vecs[5]  = '{1'b0, 5'd25, 5'd0,  5'd1,  5'd25, 5'd5,  1'b0};
        vecs[6]  = '{1'b0, 5'd0,  5'd1,  5'd0,  5'd0,  5'd10, 1'b0};
        vecs[7]  = '{1'b1, 5'd3,  5'd2,  5'd7,  5'd3,  5'd20, 1'b0};
        vecs[8]  = '{1'b1, 5'd0,  5'd0,  5'd31, 5'd0,  5'd31, 1'b1};
        vecs[9]  = '{1'b0, 5'd30, 5'd28, 5'd0,  5'd4,  5'd10, 1'b0};
        vecs[10] = '{1'b0, 5'd10, 5'd20, 5'd15, 5'd10, 5'd16, 1'b0};
        vecs[11] = '{1'b1, 5'd0,  5'd0,  5'd20, 5'd0,  5'd17, 1'b0};

        rst_n = 1'b0; cfg_load = 1'b0; cfg_pos = 5'd0; cfg_ring = 5'd0;
        step_in = 1'b0; in_valid = 1'b0; in_dir = 1'b0; in_data = 5'd0;
        out_ready = 1'b1;
        #12;
        check("reset out_valid", out_valid, 1'b0);
        check("reset in_ready", in_ready, 1'b1);
        check("reset position", position, 5'd0);
        check("reset out_data", out_data, 5'd0);
        check("reset out_err", out_err, 1'b0);
        check("reset notch", notch_out, 1'b0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            load(vecs[i].pos, vecs[i].ring);
            check($sformatf("vec%0d position", i), position, vecs[i].exp_pos);
            in_valid = 1'b1;
            in_dir   = vecs[i].dir;
            in_data  = vecs[i].data;
            tick();
            in_valid = 1'b0;
            check($sformatf("vec%0d out_valid", i), out_valid, 1'b1);
            check($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_data);
            check($sformatf("vec%0d out_err", i), out_err, vecs[i].exp_err);
        end
        in_dir = 1'b0;
        tick();
        check("drain out_valid", out_valid, 1'b0);

        // Notch at Q, and wrap from Z without carry.
        load(5'd16, 5'd0);
        step_in = 1'b1;
        tick();
        step_in = 1'b0;
        check("step 16 position", position, 5'd17);
        check("step 16 notch", notch_out, 1'b1);
        tick();
        check("notch one cycle", notch_out, 1'b0);
        load(5'd25, 5'd0);
        step_in = 1'b1;
        tick();
        step_in = 1'b0;
        check("wrap position", position, 5'd0);
        check("wrap notch", notch_out, 1'b0);
        tick();
        check("wrap notch later", notch_out, 1'b0);

        // Load wins over step.
        cfg_load = 1'b1; cfg_pos = 5'd5; cfg_ring = 5'd0; step_in = 1'b1;
        tick();
        cfg_load = 1'b0; step_in = 1'b0;
        check("load over step", position, 5'd5);

        // Data accepted alongside a step or load uses the old position.
        load(5'd0, 5'd0);
        step_in = 1'b1; in_valid = 1'b1; in_data = 5'd0;
        tick();
        step_in = 1'b0; in_valid = 1'b0;
        check("pre-step data", out_data, 5'd4);
        check("post-step position", position, 5'd1);
        cfg_load = 1'b1; cfg_pos = 5'd9; in_valid = 1'b1; in_data = 5'd0;
        tick();
        cfg_load = 1'b0; in_valid = 1'b0;
        check("pre-load data", out_data, 5'd9);
        check("post-load position", position, 5'd9);

        // Backpressure: result held, input blocked.
        load(5'd0, 5'd0);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 5'd0;
        tick();
        in_data = 5'd5;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("stall%0d in_ready", k), in_ready, 1'b0);
            check($sformatf("stall%0d out_valid", k), out_valid, 1'b1);
            check($sformatf("stall%0d out_data", k), out_data, 5'd4);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("stall drained", out_valid, 1'b0);

        // Streaming at one per cycle.
        in_valid = 1'b1; in_data = 5'd0;
        tick();
        check("stream0 data", out_data, 5'd4);
        in_data = 5'd1;
        tick();
        check("stream1 data", out_data, 5'd10);
        check("stream1 valid", out_valid, 1'b1);
        in_data = 5'd2;
        tick();
        check("stream2 data", out_data, 5'd12);
        check("stream2 valid", out_valid, 1'b1);
        in_valid = 1'b0;
        tick();
        check("stream end valid", out_valid, 1'b0);

        // In-flight result survives a later step and load.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 5'd0;
        tick();
        in_valid = 1'b0; step_in = 1'b1;
        tick();
        step_in = 1'b0;
        check("inflight after step", out_data, 5'd4);
        check("inflight step position", position, 5'd1);
        load(5'd3, 5'd0);
        check("inflight after load", out_data, 5'd4);
        check("inflight valid", out_valid, 1'b1);
        out_ready = 1'b1;
        tick();

        // Asynchronous reset while a result is pending.
        load(5'd7, 5'd3);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 5'd0;
        tick();
        in_valid = 1'b0;
        check("pre-reset valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset valid", out_valid, 1'b0);
        check("async reset position", position, 5'd0);
        check("async reset in_ready", in_ready, 1'b1);
        check("async reset data", out_data, 5'd0);
        tick();
        rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 5'd0;
        tick();
        in_valid = 1'b0;
        check("post-reset data", out_data, 5'd4);
        check("post-reset valid", out_valid, 1'b1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/enigma_rotor_stage.md
ENIGMA_ROTOR_STAGE -- requirements
Module: enigma_rotor_stage

Interface
REQ-001 SHALL have parameter ALPHA, default 26, alphabet size (2..32).
REQ-002 SHALL have parameter W, default 5, symbol width; ALPHA <= 2**W.
REQ-003 SHALL have parameter ROTOR_ID, default 0, wiring select 0..4 = rotors I..V.
REQ-004 SHALL have port clk  in  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports cfg_load  in  1, cfg_pos  in  W, cfg_ring  in  W: load start position and ring setting.
REQ-007 SHALL have port step_in  in  1  advance position by one.
REQ-008 SHALL have ports in_valid  in  1, in_ready  out  1, in_dir  in  1 (0 = forward, 1 = reverse), in_data  in  W.
REQ-009 SHALL have ports out_valid  out  1, out_ready  in  1, out_data  out  W, out_err  out  1.
REQ-010 SHALL have ports position  out  W (current position) and notch_out  out  1 (carry to next rotor).

Function
REQ-011 SHALL map forward: out = (WIRE[(in + pos - ring) mod ALPHA] - pos + ring) mod ALPHA.
REQ-012 SHALL map reverse identically, but through the inverse table INV.
REQ-013 SHALL perform all mod-ALPHA arithmetic by conditional add/subtract of ALPHA; no divide or % operator.
REQ-014 SHALL accept input when in_valid && in_ready; in_ready = !out_valid || out_ready.
REQ-015 SHALL register the result, giving out_valid one cycle after acceptance (latency 1).
REQ-016 SHALL hold out_data/out_err stable while out_valid && !out_ready.
REQ-017 SHALL clear out_valid on out_ready unless a new input is accepted in the same cycle; back-to-back throughput is 1/cycle.
REQ-018 SHALL implement the output stage as a two-state FSM: EMPTY -> FULL on accept; FULL -> EMPTY on drain without accept; FULL -> FULL on drain+accept.
REQ-019 SHALL, when in_data >= ALPHA, pass in_data unchanged with out_err = 1; otherwise out_err = 0.
REQ-020 SHALL, on step_in, set pos <= (pos + 1) mod ALPHA; ALPHA-1 wraps to 0.
REQ-021 SHALL pulse notch_out for exactly one cycle, the cycle after a step taken while pos == NOTCH[ROTOR_ID].
REQ-022 SHALL apply cfg_load over step_in when both are asserted; cfg_pos/cfg_ring values >= ALPHA are reduced by one subtraction of ALPHA.
REQ-023 SHALL use the pre-step (or pre-load) position for data accepted in the same cycle as step_in or cfg_load.
REQ-024 SHALL leave an in-flight result unaffected by a later step or load.

Reset
REQ-025 SHALL, on rst_n low, immediately force pos = 0, ring = 0, out_valid = 0, out_data = 0, out_err = 0 and notch_out = 0.
REQ-026 SHALL drive in_ready = 1 in reset.
REQ-027 SHALL discard any pending result when reset is asserted mid-operation.
REQ-028 SHALL accept no input and no step until the first rising edge after rst_n deasserts.

Structure
REQ-029 SHALL take the following from shared package enigma_pkg: ALPHA_DEFAULT, W_DEFAULT, WIRE[5][26], INV[5][26] and NOTCH[5] (Q, E, V, J, Z = 16, 4, 21, 9, 25).
REQ-030 SHALL instantiate one sub-module, enigma_mod_add (W, ALPHA; a + b or a - b mod ALPHA), four times.

Verification
REQ-031 SHALL cover: ROTOR_ID=0, pos=0, ring=0, forward in=0 -> out_data=4 (E) one cycle later, out_err=0.
REQ-032 SHALL cover: ROTOR_ID=0, pos=1, ring=0, forward in=0 -> out_data=9 (J); reverse in=4 at pos=0 -> 0.
REQ-033 SHALL cover: ROTOR_ID=0, cfg_pos=16, step_in -> position=17 and notch_out high one cycle; step from 25 -> position=0 with no notch.
REQ-034 SHALL cover: out_ready=0 for 3 cycles after accept -> in_ready=0, out_data held; out_ready=1 -> drained, and streaming inputs 0,1,2 give 4,10,12.
REQ-035 SHALL cover: in_data=27 -> out_data=27, out_err=1; cfg_load + step_in same cycle with cfg_pos=5 -> position=5.
REQ-036 SHALL cover: rst_n low while out_valid=1 -> out_valid=0 and position=0 immediately, before the next clock edge.
